// File: rtl/fifo_rd_stream.sv
// Drains a 1-cycle-latency FIFO into a valid/ready stream via a 2-entry skid buffer.
// Groups words into PKT_LEN-word packets and keeps a sticky error flag.
module fifo_rd_stream #(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic             rd_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             empty,
    input  logic             rd_err,
    input  logic [WIDTH-1:0] rdata,
    output logic             rd_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic             err
);

    localparam int WC_W = $clog2(PKT_LEN);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(PKT_LEN - 1);

    logic [1:0]       occ_q, occ_d;
    logic             pend_q;
    logic [WIDTH-1:0] buf_q [2];
    logic [WIDTH-1:0] buf_d [2];
    logic [WC_W-1:0]  word_q, word_d;
    logic [CNT_W-1:0] pkt_q, pkt_d;
    logic             err_q, err_d;
    logic             pop;
    logic [2:0]       fill;
    logic [1:0]       wr_idx;

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = buf_q[0];
    assign out_last  = out_valid && (word_q == WC_MAX);
    assign pkt_cnt   = pkt_q;
    assign err       = err_q;

    always_comb begin
        pop    = out_valid && out_ready;
        // Projected occupancy once this cycle's capture and pop both land.
        fill   = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
        rd_en  = !rst && en && !empty && (fill < 3'd2);
        wr_idx = occ_q - {1'b0, pop};
        occ_d  = fill[1:0];
        buf_d  = buf_q;
        word_d = word_q;
        pkt_d  = pkt_q;
        err_d  = err_q | rd_err | (rd_en & empty);
        if (pop) begin
            buf_d[0] = buf_q[1];
            word_d   = (word_q == WC_MAX) ? '0 : word_q + 1'b1;
            if (word_q == WC_MAX) begin
                pkt_d = pkt_q + 1'b1;
            end
        end
        // Tail slot is computed after the pop shift so a full buffer can swap.
        if (pend_q) begin
            buf_d[wr_idx[0]] = rdata;
        end
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            occ_q    <= 2'd0;
            pend_q   <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            word_q   <= '0;
            pkt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            pend_q <= rd_en;
            buf_q  <= buf_d;
            word_q <= word_d;
            pkt_q  <= pkt_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural 1-cycle-latency FIFO.
// Vector table covers the streaming case; hand sequences cover the corners.
module tb_fifo_rd_stream;

    logic        rd_clk;
    logic        rst;
    logic        en;
    logic        empty;
    logic        rd_err;
    logic [7:0]  rdata;
    logic        rd_en;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [15:0] pkt_cnt;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [64];
    int         rd_ptr = 0;
    int         wr_ptr = 0;
    logic [7:0] got [$];
    int         rd_cnt;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        rden;
        logic        vld;
        logic [7:0]  data;
        logic        last;
        logic [15:0] pkt;
    } vec_t;

    vec_t tbl [11];

    fifo_rd_stream #(.WIDTH(8), .PKT_LEN(4), .CNT_W(16)) dut (
        .rd_clk    (rd_clk),
        .rst       (rst),
        .en        (en),
        .empty     (empty),
        .rd_err    (rd_err),
        .rdata     (rdata),
        .rd_en     (rd_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .pkt_cnt   (pkt_cnt),
        .err       (err)
    );

    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    assign empty = (rd_ptr == wr_ptr);

    always @(posedge rd_clk) begin
        if (rd_en && !empty) begin
            rdata  <= mem[rd_ptr % 64];
            rd_ptr <= rd_ptr + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge rd_clk);
        @(negedge rd_clk);
    endtask

    task automatic sample();
        if (out_valid && out_ready) got.push_back(out_data);
        if (rd_en) rd_cnt++;
    endtask

    task automatic preload(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 64] = base + 8'(i);
            wr_ptr++;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b0;
        out_ready = 1'b0;
        rd_err    = 1'b0;
        step();
        step();
        wr_ptr = rd_ptr;
        got.delete();
        rd_cnt = 0;
        rst = 1'b0;
    endtask

    initial begin
        int  max_occ;
        int  unstable;
        logic       prev_hold;
        logic [7:0] prev_data;

        tbl[0]  = '{1, 1, 1, 0, 8'h00, 0, 16'd0};
        tbl[1]  = '{1, 1, 1, 0, 8'h00, 0, 16'd0};
        tbl[2]  = '{1, 1, 1, 1, 8'h01, 0, 16'd0};
        tbl[3]  = '{1, 1, 1, 1, 8'h02, 0, 16'd0};
        tbl[4]  = '{1, 1, 1, 1, 8'h03, 0, 16'd0};
        tbl[5]  = '{1, 1, 1, 1, 8'h04, 1, 16'd0};
        tbl[6]  = '{1, 1, 1, 1, 8'h05, 0, 16'd1};
        tbl[7]  = '{1, 1, 1, 1, 8'h06, 0, 16'd1};
        tbl[8]  = '{1, 1, 0, 1, 8'h07, 0, 16'd1};
        tbl[9]  = '{1, 1, 0, 1, 8'h08, 1, 16'd1};
        tbl[10] = '{1, 1, 0, 0, 8'h00, 0, 16'd2};

        // Reset held with en high and the FIFO empty.
        rst = 1'b1; en = 1'b1; out_ready = 1'b1; rd_err = 1'b0;
        rd_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rst_rden", rd_en, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_last", out_last, 0);
            chk("rst_data", out_data, 0);
            chk("rst_pkt", pkt_cnt, 0);
            chk("rst_err", err, 0);
            step();
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("idle_rden", rd_en, 0);
            chk("idle_valid", out_valid, 0);
            chk("idle_pkt", pkt_cnt, 0);
            step();
        end

        // Streaming: 8 words, back-to-back.
        do_reset();
        preload(8, 8'h01);
        for (int i = 0; i < 11; i++) begin
            en = tbl[i].en;
            out_ready = tbl[i].rdy;
            #1;
            chk($sformatf("str%0d_rden", i), rd_en, tbl[i].rden);
            chk($sformatf("str%0d_vld", i), out_valid, tbl[i].vld);
            if (tbl[i].vld) chk($sformatf("str%0d_data", i), out_data, tbl[i].data);
            chk($sformatf("str%0d_last", i), out_last, tbl[i].last);
            chk($sformatf("str%0d_pkt", i), pkt_cnt, tbl[i].pkt);
            step();
        end

        // Backpressure: fill to 2 and hold, then drain.
        do_reset();
        preload(4, 8'h01);
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            sample();
            step();
        end
        #1;
        chk("bp_rdcnt", rd_cnt, 2);
        chk("bp_occ", dut.occ_q, 2);
        chk("bp_valid", out_valid, 1);
        chk("bp_data", out_data, 8'h01);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && got.size() < 4; i++) begin
            #1;
            sample();
            step();
        end
        chk("bp_count", got.size(), 4);
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("bp_word%0d", i), got[i], 8'(i + 1));
        chk("bp_pkt", pkt_cnt, 1);

        // Random out_ready over 16 words.
        do_reset();
        preload(16, 8'h10);
        en = 1'b1;
        max_occ = 0;
        unstable = 0;
        prev_hold = 1'b0;
        prev_data = 8'h00;
        for (int i = 0; i < 300 && got.size() < 16; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (int'(dut.occ_q) > max_occ) max_occ = int'(dut.occ_q);
            if (prev_hold && (!out_valid || out_data !== prev_data)) unstable++;
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            sample();
            step();
        end
        chk("rnd_count", got.size(), 16);
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("rnd_word%0d", i), got[i], 8'h10 + 8'(i));
        chk("rnd_occ_le2", max_occ <= 2, 1);
        chk("rnd_stable", unstable, 0);
        chk("rnd_pkt", pkt_cnt, 4);

        // Drop en with one read in flight.
        do_reset();
        preload(4, 8'h01);
        en = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("en_first_rden", rd_en, 1);
        sample();
        step();
        en = 1'b0;
        #1;
        chk("en_drop_rden", rd_en, 0);
        for (int i = 0; i < 8; i++) begin
            sample();
            step();
            #1;
        end
        chk("en_rdcnt", rd_cnt, 1);
        chk("en_count", got.size(), 1);
        if (got.size() > 0) chk("en_word", got[0], 8'h01);
        chk("en_valid_end", out_valid, 0);

        // Sticky error, then async reset with a full buffer.
        @(negedge rd_clk);
        do_reset();
        #1;
        chk("err_pre", err, 0);
        rd_err = 1'b1;
        step();
        rd_err = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("err_hold%0d", i), err, 1);
            step();
        end
        preload(4, 8'h01);
        en = 1'b1;
        for (int i = 0; i < 4; i++) step();
        #1;
        chk("ar_occ", dut.occ_q, 2);
        chk("ar_valid_pre", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_rden", rd_en, 0);
        chk("ar_data", out_data, 0);
        chk("ar_err", err, 0);
        chk("ar_occ0", dut.occ_q, 0);
        step();
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
